// File: rtl/dvp_capture_pkg.sv
// Shared types and constants for the DVP frame capture controller.
package dvp_capture_pkg;

  localparam int DVP_DATA_W    = 8;
  localparam int PXL_INFO_W    = DVP_DATA_W + 2;
  localparam int BYTES_PER_PXL = 2;
  localparam int DIM_W         = 12;
  localparam int LB_W          = DIM_W + 2;
  localparam int FCNT_W        = 16;

  // Marker bits carried above the data byte in each FIFO entry.
  localparam int VSYNC_BIT = DVP_DATA_W + 1;
  localparam int HSYNC_BIT = DVP_DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_ERROR    = 2'd3
  } cap_state_t;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_LINE_SHORT = 2'd1;
  localparam logic [1:0] ERR_LINE_LONG  = 2'd2;
  localparam logic [1:0] ERR_FRAME      = 2'd3;

  // Bytes per line for a given pixel width, wide enough that it never overflows.
  function automatic logic [LB_W-1:0] calc_line_bytes(input logic [DIM_W-1:0] w);
    return LB_W'(w) * LB_W'(BYTES_PER_PXL);
  endfunction

endpackage

// File: rtl/dvp_geom_checker.sv
// Byte/line position tracking within a frame and geometry error detection
// for the entry currently presented by the pixel FIFO.
module dvp_geom_checker
  import dvp_capture_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic [LB_W-1:0] line_bytes,
  input  logic [DIM_W-1:0] img_h,
  input  logic            ent_vld,
  input  logic            vsync,
  input  logic            hsync,
  input  logic            accept,
  output logic            frame_last,
  output logic            err_line_short,
  output logic            err_line_long,
  output logic            err_frame_short
);

  logic [LB_W-1:0]  byte_cnt;
  logic [DIM_W-1:0] line_cnt;
  logic             first_byte;
  logic             line_full;
  logic             last_line;
  logic             line_end_byte;
  logic             any_err;

  // byte_cnt counts bytes already accepted on the current line; both zero
  // means the next entry is the frame's first byte (the SOF entry).
  assign first_byte    = (byte_cnt == '0) && (line_cnt == '0);
  assign line_full     = (byte_cnt == line_bytes);
  assign last_line     = (line_cnt == (img_h - DIM_W'(1)));
  assign line_end_byte = (byte_cnt == (line_bytes - LB_W'(1)));

  // A stray VSYNC takes precedence so a truncated frame always reports code 3.
  assign err_frame_short = ent_vld && vsync && !first_byte;
  assign err_line_short  = ent_vld && !vsync && hsync && !first_byte && !line_full;
  assign err_line_long   = ent_vld && !vsync && !hsync && line_full;
  assign any_err         = err_frame_short || err_line_short || err_line_long;

  assign frame_last = ent_vld && last_line && line_end_byte && !any_err;

  // Position counters advance only on bytes actually forwarded downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      line_cnt <= '0;
    end else if (clr) begin
      byte_cnt <= '0;
      line_cnt <= '0;
    end else if (accept) begin
      if (frame_last) begin
        byte_cnt <= '0;
        line_cnt <= '0;
      end else if (hsync && !first_byte) begin
        byte_cnt <= LB_W'(1);
        line_cnt <= line_cnt + DIM_W'(1);
      end else begin
        byte_cnt <= byte_cnt + LB_W'(1);
      end
    end
  end

endmodule

// File: rtl/dvp_capture_ctrl.sv
// Frame-level capture controller between the DVP pixel FIFO and the
// byte-to-RGB565 concat stage.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | stopped; FIFO not popped, nothing forwarded
//   ST_WAIT_SOF | armed; discard entries until a VSYNC entry is at the head
//   ST_CAPTURE  | forwarding frame bytes, checking line length / line count
//   ST_ERROR    | sticky error; FIFO drained until dcr_err_clr_i
module dvp_capture_ctrl
  import dvp_capture_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PXL_INFO_W-1:0] pxl_info_i,
  input  logic                  pxl_info_vld_i,
  output logic                  pxl_info_rdy_o,
  input  logic                  dcr_cam_start_i,
  input  logic                  dcr_cam_stop_i,
  input  logic                  dcr_single_i,
  input  logic [DIM_W-1:0]      dcr_img_w_i,
  input  logic [DIM_W-1:0]      dcr_img_h_i,
  input  logic                  dcr_err_clr_i,
  output logic [DVP_DATA_W-1:0] pxl_byte_o,
  output logic                  pxl_byte_vld_o,
  input  logic                  pxl_byte_rdy_i,
  output logic                  frame_done_o,
  output logic                  err_irq_o,
  output logic [1:0]            err_code_o,
  output logic                  busy_o,
  output logic [FCNT_W-1:0]     frame_cnt_o
);

  cap_state_t        state;
  logic [LB_W-1:0]   line_bytes_q;
  logic [DIM_W-1:0]  img_h_q;
  logic              single_q;
  logic              stop_pending;
  logic              frame_done_q;
  logic              err_irq_q;
  logic [1:0]        err_code_q;
  logic [FCNT_W-1:0] frame_cnt_q;

  logic              vsync;
  logic              hsync;
  logic              ent_vld;
  logic              accept;
  logic              geom_err;
  logic              frame_last;
  logic              err_line_short;
  logic              err_line_long;
  logic              err_frame_short;
  logic [1:0]        err_code_nxt;
  logic              cfg_bad;

  assign vsync    = pxl_info_i[VSYNC_BIT];
  assign hsync    = pxl_info_i[HSYNC_BIT];
  assign ent_vld  = (state == ST_CAPTURE) && pxl_info_vld_i;
  assign geom_err = err_line_short || err_line_long || err_frame_short;
  assign accept   = ent_vld && !geom_err && pxl_byte_rdy_i;
  assign cfg_bad  = (dcr_img_w_i == '0) || (dcr_img_h_i == '0);

  assign err_code_nxt = err_frame_short ? ERR_FRAME :
                        err_line_short  ? ERR_LINE_SHORT : ERR_LINE_LONG;

  dvp_geom_checker u_geom (
    .clk             (clk),
    .rst_n           (rst_n),
    .clr             (state != ST_CAPTURE),
    .line_bytes      (line_bytes_q),
    .img_h           (img_h_q),
    .ent_vld         (ent_vld),
    .vsync           (vsync),
    .hsync           (hsync),
    .accept          (accept),
    .frame_last      (frame_last),
    .err_line_short  (err_line_short),
    .err_line_long   (err_line_long),
    .err_frame_short (err_frame_short)
  );

  assign pxl_byte_o = pxl_info_i[DVP_DATA_W-1:0];

  // Zero-latency handshake: downstream backpressure reaches the FIFO in the
  // same cycle, and an offending entry is popped without being forwarded.
  always_comb begin
    pxl_info_rdy_o = 1'b0;
    pxl_byte_vld_o = 1'b0;
    case (state)
      ST_WAIT_SOF: pxl_info_rdy_o = !(pxl_info_vld_i && vsync);
      ST_CAPTURE: begin
        pxl_byte_vld_o = pxl_info_vld_i && !geom_err;
        pxl_info_rdy_o = geom_err || pxl_byte_rdy_i;
      end
      ST_ERROR:    pxl_info_rdy_o = 1'b1;
      default:     ;
    endcase
  end

  // Capture sequencing, latched geometry, error capture and frame counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      line_bytes_q <= '0;
      img_h_q      <= '0;
      single_q     <= 1'b0;
      stop_pending <= 1'b0;
      frame_done_q <= 1'b0;
      err_irq_q    <= 1'b0;
      err_code_q   <= ERR_NONE;
      frame_cnt_q  <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dcr_cam_start_i && !dcr_cam_stop_i) begin
            line_bytes_q <= calc_line_bytes(dcr_img_w_i);
            img_h_q      <= dcr_img_h_i;
            single_q     <= dcr_single_i;
            stop_pending <= 1'b0;
            if (cfg_bad) begin
              state      <= ST_ERROR;
              err_irq_q  <= 1'b1;
              err_code_q <= ERR_FRAME;
            end else begin
              state <= ST_WAIT_SOF;
            end
          end
        end
        ST_WAIT_SOF: begin
          if (dcr_cam_stop_i) begin
            state <= ST_IDLE;
          end else if (pxl_info_vld_i && vsync) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (dcr_cam_stop_i) begin
            stop_pending <= 1'b1;
          end
          if (geom_err) begin
            state        <= ST_ERROR;
            err_irq_q    <= 1'b1;
            err_code_q   <= err_code_nxt;
            stop_pending <= 1'b0;
          end else if (accept && frame_last) begin
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + FCNT_W'(1);
            stop_pending <= 1'b0;
            if (single_q || stop_pending || dcr_cam_stop_i) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_WAIT_SOF;
            end
          end
        end
        ST_ERROR: begin
          if (dcr_err_clr_i) begin
            state      <= ST_IDLE;
            err_irq_q  <= 1'b0;
            err_code_q <= ERR_NONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign frame_done_o = frame_done_q;
  assign err_irq_o    = err_irq_q;
  assign err_code_o   = err_code_q;
  assign busy_o       = (state != ST_IDLE);
  assign frame_cnt_o  = frame_cnt_q;

endmodule
